dcache_miss_arbiter: RTL and testbench

Shares the external memory channels among the data cache's miss ports. Each cache consumer slot that misses raises a read fill or write-back/write-through request. The arbiter grants up to NUM_CHANNELS requests concurrently using round-robin order, runs a per-channel handshake state machine against memory, and relays the result back to the requesting slot.

---
 rtl/dcache_miss_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dcache_miss_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS memory channels among the data
// cache miss slots; each channel runs its own request/relay handshake.
module dcache_miss_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address,
    input  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
    output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int unsigned NC  = NUM_CONSUMERS;
    localparam int unsigned NCH = NUM_CHANNELS;
    localparam int unsigned AB  = ADDR_BITS;
    localparam int unsigned DB  = DATA_BITS;
    localparam int unsigned CW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                r_state    [NCH];
    state_t                w_state_nx [NCH];
    logic [CW-1:0]         r_owner    [NCH];
    logic [CW-1:0]         w_owner_nx [NCH];
    logic [NC-1:0]         r_claim, w_claim_nx;
    logic [NC-1:0]         w_taken;
    logic [CW-1:0]         r_rr, w_rr_nx;
    logic [CW-1:0]         w_c, w_pick;
    logic                  w_found;

    logic [NCH-1:0]        r_mrv, w_mrv_nx, r_mwv, w_mwv_nx;
    logic [AB*NCH-1:0]     r_mra, w_mra_nx, r_mwa, w_mwa_nx;
    logic [DB*NCH-1:0]     r_mwd, w_mwd_nx;
    logic [NC-1:0]         r_crr, w_crr_nx, r_cwr, w_cwr_nx;
    logic [DB*NC-1:0]      r_crd, w_crd_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                r_state[ch] <= IDLE;
                r_owner[ch] <= '0;
            end
            r_claim <= '0;
            r_rr    <= '0;
            r_mrv   <= '0;
            r_mra   <= '0;
            r_mwv   <= '0;
            r_mwa   <= '0;
            r_mwd   <= '0;
            r_crr   <= '0;
            r_crd   <= '0;
            r_cwr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_claim <= w_claim_nx;
            r_rr    <= w_rr_nx;
            r_mrv   <= w_mrv_nx;
            r_mra   <= w_mra_nx;
            r_mwv   <= w_mwv_nx;
            r_mwa   <= w_mwa_nx;
            r_mwd   <= w_mwd_nx;
            r_crr   <= w_crr_nx;
            r_crd   <= w_crd_nx;
            r_cwr   <= w_cwr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_claim_nx = r_claim;
        w_rr_nx    = r_rr;
        w_taken    = '0;
        w_c        = '0;
        w_pick     = '0;
        w_found    = 1'b0;
        w_mrv_nx   = r_mrv;
        w_mra_nx   = r_mra;
        w_mwv_nx   = r_mwv;
        w_mwa_nx   = r_mwa;
        w_mwd_nx   = r_mwd;
        w_crr_nx   = r_crr;
        w_crd_nx   = r_crd;
        w_cwr_nx   = r_cwr;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            case (r_state[ch])
                IDLE: begin
                    // r_claim (not the next-state copy) keeps a just-released slot out until next cycle
                    w_found = 1'b0;
                    w_pick  = '0;
                    for (int unsigned k = 0; k < NC; k++) begin
                        w_c = CW'((r_rr + k) % NC);
                        if (!w_found && (consumer_read_valid[w_c] || consumer_write_valid[w_c])
                                && !r_claim[w_c] && !w_taken[w_c]) begin
                            w_found = 1'b1;
                            w_pick  = w_c;
                        end
                    end
                    if (w_found) begin
                        w_taken[w_pick]    = 1'b1;
                        w_claim_nx[w_pick] = 1'b1;
                        w_owner_nx[ch]     = w_pick;
                        w_rr_nx            = CW'((w_pick + 1) % NC);
                        if (consumer_read_valid[w_pick]) begin
                            w_mrv_nx[ch]            = 1'b1;
                            w_mra_nx[ch*AB +: AB]   = consumer_read_address[w_pick*AB +: AB];
                            w_state_nx[ch]          = READ_WAITING;
                        end else begin
                            w_mwv_nx[ch]            = 1'b1;
                            w_mwa_nx[ch*AB +: AB]   = consumer_write_address[w_pick*AB +: AB];
                            w_mwd_nx[ch*DB +: DB]   = consumer_write_data[w_pick*DB +: DB];
                            w_state_nx[ch]          = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        w_mrv_nx[ch]                     = 1'b0;
                        w_crr_nx[r_owner[ch]]            = 1'b1;
                        w_crd_nx[r_owner[ch]*DB +: DB]   = mem_read_data[ch*DB +: DB];
                        w_state_nx[ch]                   = READ_RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        w_mwv_nx[ch]          = 1'b0;
                        w_cwr_nx[r_owner[ch]] = 1'b1;
                        w_state_nx[ch]        = WRITE_RELAYING;
                    end
                end
                READ_RELAYING: begin
                    if (!consumer_read_valid[r_owner[ch]]) begin
                        w_crr_nx[r_owner[ch]]   = 1'b0;
                        w_claim_nx[r_owner[ch]] = 1'b0;
                        w_state_nx[ch]          = IDLE;
                    end
                end
                WRITE_RELAYING: begin
                    if (!consumer_write_valid[r_owner[ch]]) begin
                        w_cwr_nx[r_owner[ch]]   = 1'b0;
                        w_claim_nx[r_owner[ch]] = 1'b0;
                        w_state_nx[ch]          = IDLE;
                    end
                end
                default: w_state_nx[ch] = IDLE;
            endcase
        end
    end

    assign mem_read_valid       = r_mrv;
    assign mem_read_address     = r_mra;
    assign mem_write_valid      = r_mwv;
    assign mem_write_address    = r_mwa;
    assign mem_write_data       = r_mwd;
    assign consumer_read_ready  = r_crr;
    assign consumer_read_data   = r_crd;
    assign consumer_write_ready = r_cwr;

endmodule

// File: tb/tb_dcache_miss_arbiter.sv
// Bench for dcache_miss_arbiter: table of single transactions plus contention,
// read/write conflict, reset and single-channel fairness sequences.
module tb_dcache_miss_arbiter;

    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [NC-1:0]   a_crv, a_crr, a_cwv, a_cwr;
    logic [8*NC-1:0] a_cra, a_crd, a_cwa, a_cwd;
    logic [1:0]      a_mrv, a_mrr, a_mwv, a_mwr, a_prv, a_pwv;
    logic [15:0]     a_mra, a_mrd, a_mwa, a_mwd;

    logic [NC-1:0]   b_crv, b_crr, b_cwv, b_cwr;
    logic [8*NC-1:0] b_cra, b_crd, b_cwa, b_cwd;
    logic [0:0]      b_mrv, b_mrr, b_mwv, b_mwr, b_prv;
    logic [7:0]      b_mra, b_mrd, b_mwa, b_mwd;

    dcache_miss_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    dcache_miss_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    typedef struct {
        int         slot;
        bit         wr;
        logic [7:0] data;
    } resp_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } memx_t;

    typedef struct {
        int         slot;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    resp_t      sb_q[$];
    memx_t      mem_q[$];
    logic [7:0] glog[$];
    logic [7:0] bglog[$];
    vec_t       vecs[6];

    int checks = 0;
    int errors = 0;
    int mem_lat;
    int a_cnt[2];
    int b_cnt;
    int b_want[NC];

    function automatic logic [7:0] mem_fn(input logic [7:0] addr);
        return addr + 8'h69;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic req(input int slot, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd);
        resp_t r;
        memx_t m;
        if (wr) begin
            a_cwv[slot] = 1'b1;
            a_cwa[slot*8 +: 8] = addr;
            a_cwd[slot*8 +: 8] = wdata;
        end else begin
            a_crv[slot] = 1'b1;
            a_cra[slot*8 +: 8] = addr;
        end
        r.slot = slot; r.wr = wr; r.data = wr ? 8'h00 : exp_rd;
        m.wr = wr; m.addr = addr; m.data = wdata;
        sb_q.push_back(r);
        mem_q.push_back(m);
    endtask

    task automatic sb_match(input int slot, input bit wr, input logic [7:0] data);
        int idx = -1;
        for (int i = 0; i < sb_q.size(); i++)
            if (idx < 0 && sb_q[i].slot == slot && sb_q[i].wr == wr) idx = i;
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: slot %0d wr %0d got response, expected none", slot, wr);
        end else begin
            chk($sformatf("resp_slot%0d_wr%0d", slot, wr), data, sb_q[idx].data);
            sb_q.delete(idx);
        end
    endtask

    task automatic mem_match(input bit wr, input logic [7:0] addr, input logic [7:0] data);
        int idx = -1;
        for (int i = 0; i < mem_q.size(); i++)
            if (idx < 0 && mem_q[i].wr == wr && mem_q[i].addr == addr) idx = i;
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL memside_unexpected: wr %0d addr %0h issued, expected none", wr, addr);
        end else begin
            if (wr) chk("mem_write_data", data, mem_q[idx].data);
            mem_q.delete(idx);
        end
    endtask

    // Consumer and memory agents, all evaluated at the falling edge.
    task automatic agents();
        for (int s = 0; s < NC; s++) begin
            if (a_crv[s] && a_crr[s]) begin
                sb_match(s, 1'b0, a_crd[s*8 +: 8]);
                a_crv[s] = 1'b0;
            end
            if (a_cwv[s] && a_cwr[s]) begin
                sb_match(s, 1'b1, 8'h00);
                a_cwv[s] = 1'b0;
            end
            if (b_crv[s] && b_crr[s]) b_crv[s] = 1'b0;
            else if (!b_crv[s] && !b_crr[s] && b_want[s] > 0) begin
                b_crv[s] = 1'b1;
                b_want[s]--;
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            if (a_mrv[ch] && !a_prv[ch]) begin
                glog.push_back(a_mra[ch*8 +: 8]);
                mem_match(1'b0, a_mra[ch*8 +: 8], 8'h00);
            end
            if (a_mwv[ch] && !a_pwv[ch]) mem_match(1'b1, a_mwa[ch*8 +: 8], a_mwd[ch*8 +: 8]);
            if (a_mrr[ch] || a_mwr[ch]) begin
                a_mrr[ch] = 1'b0;
                a_mwr[ch] = 1'b0;
            end else if (a_mrv[ch] || a_mwv[ch]) begin
                a_cnt[ch]++;
                if (a_cnt[ch] >= mem_lat) begin
                    a_cnt[ch] = 0;
                    if (a_mrv[ch]) begin
                        a_mrr[ch] = 1'b1;
                        a_mrd[ch*8 +: 8] = mem_fn(a_mra[ch*8 +: 8]);
                    end else a_mwr[ch] = 1'b1;
                end
            end
        end
        a_prv = a_mrv;
        a_pwv = a_mwv;
        if (b_mrv[0] && !b_prv[0]) bglog.push_back(b_mra);
        if (b_mrr[0]) b_mrr[0] = 1'b0;
        else if (b_mrv[0]) begin
            b_cnt++;
            if (b_cnt >= 1) begin
                b_cnt = 0;
                b_mrr[0] = 1'b1;
                b_mrd = mem_fn(b_mra);
            end
        end
        b_prv = b_mrv;
    endtask

    task automatic step();
        @(negedge clk);
        agents();
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            done = (sb_q.size() == 0) && (mem_q.size() == 0) && (a_crv == 0) && (a_cwv == 0)
                && (a_crr == 0) && (a_cwr == 0) && (a_mrv == 0) && (a_mwv == 0)
                && (b_crv == 0) && (b_crr == 0) && (b_mrv == 0);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_%s: outstanding %0d responses, expected 0", name, sb_q.size());
            sb_q.delete();
            mem_q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{slot: 2, wr: 1'b0, addr: 8'h3C, wdata: 8'h00, exp_rd: 8'hA5};
        vecs[1] = '{slot: 1, wr: 1'b1, addr: 8'h20, wdata: 8'h7E, exp_rd: 8'h00};
        vecs[2] = '{slot: 0, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'h79};
        vecs[3] = '{slot: 3, wr: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rd: 8'hE9};
        vecs[4] = '{slot: 2, wr: 1'b1, addr: 8'hFF, wdata: 8'h11, exp_rd: 8'h00};
        vecs[5] = '{slot: 3, wr: 1'b0, addr: 8'hF0, wdata: 8'h00, exp_rd: 8'h59};

        reset = 1'b1;
        a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0; a_prv = '0; a_pwv = '0;
        b_crv = '0; b_cra = '0; b_cwv = '0; b_cwa = '0; b_cwd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0; b_prv = '0;
        a_cnt[0] = 0; a_cnt[1] = 0; b_cnt = 0;
        for (int s = 0; s < NC; s++) begin
            b_want[s] = 0;
            b_cra[s*8 +: 8] = 8'h40 + 8'(s);
        end
        mem_lat = 3;
        step(); step();
        chk("rst_mem_read_valid", {30'd0, a_mrv}, 32'd0);
        chk("rst_consumer_ready", {24'd0, a_crr, a_cwr}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Single transactions, memory answers 3 cycles after the request
        for (int v = 0; v < 6; v++) begin
            req(vecs[v].slot, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd);
            step();
            if (vecs[v].wr) begin
                chk($sformatf("v%0d_grant_wr_valid", v), {31'd0, a_mwv[0]}, 32'd1);
                chk($sformatf("v%0d_grant_wr_addr", v), {24'd0, a_mwa[7:0]}, {24'd0, vecs[v].addr});
                chk($sformatf("v%0d_no_rd_valid", v), {30'd0, a_mrv}, 32'd0);
            end else begin
                chk($sformatf("v%0d_grant_rd_valid", v), {31'd0, a_mrv[0]}, 32'd1);
                chk($sformatf("v%0d_grant_rd_addr", v), {24'd0, a_mra[7:0]}, {24'd0, vecs[v].addr});
                chk($sformatf("v%0d_no_wr_valid", v), {30'd0, a_mwv}, 32'd0);
            end
            wait_done($sformatf("vec%0d", v));
            chk($sformatf("v%0d_idle_ready", v), {24'd0, a_crr, a_cwr}, 32'd0);
        end

        // Contention: four reads, two channels, memory answers after one cycle
        mem_lat = 1;
        glog.delete();
        for (int s = 0; s < NC; s++) req(s, 1'b0, 8'(s), 8'h00, 8'h69 + 8'(s));
        wait_done("contention");
        chk("contention_grants", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk($sformatf("contention_order%0d", i), {24'd0, glog[i]}, i);

        // Read and write raised together on one slot: read goes first
        mem_lat = 2;
        req(0, 1'b0, 8'h33, 8'h00, 8'h9C);
        req(0, 1'b1, 8'h44, 8'h99, 8'h00);
        step();
        chk("rw_read_first", {30'd0, a_mrv}, 32'd1);
        chk("rw_no_write", {30'd0, a_mwv}, 32'd0);
        wait_done("rw_conflict");

        // Reset while a read is waiting on memory
        mem_lat = 30;
        req(1, 1'b0, 8'h55, 8'h00, 8'hBE);
        step(); step();
        chk("pre_reset_waiting", {31'd0, a_mrv[0]}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_mem_valid", {28'd0, a_mrv, a_mwv}, 32'd0);
        chk("reset_mem_addr", {16'd0, a_mra}, 32'd0);
        chk("reset_consumer", {24'd0, a_crr, a_cwr}, 32'd0);
        sb_q.delete(); mem_q.delete();
        a_crv = '0; a_cwv = '0; a_mrr = '0; a_mwr = '0;
        a_cnt[0] = 0; a_cnt[1] = 0;
        step();
        reset = 1'b0;
        mem_lat = 1;
        req(0, 1'b0, 8'h10, 8'h00, 8'h79);
        step();
        chk("post_reset_grant", {31'd0, a_mrv[0]}, 32'd1);
        chk("post_reset_addr", {24'd0, a_mra[7:0]}, 32'h10);
        wait_done("post_reset");

        // Single channel: slot 0 re-requests immediately, slot 3 must go first
        bglog.delete();
        b_crv[0] = 1'b1;
        b_crv[3] = 1'b1;
        b_want[0] = 1;
        wait_done("fairness");
        chk("fair_grants", bglog.size(), 3);
        if (bglog.size() >= 3) begin
            chk("fair_first", {24'd0, bglog[0]}, 32'h40);
            chk("fair_second", {24'd0, bglog[1]}, 32'h43);
            chk("fair_third", {24'd0, bglog[2]}, 32'h40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
